// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage.
// Contents: dm_ctrl access-type codes, FSM state encoding, access-size
// decode helpers and the default bus timeout.
package mem_access_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF_S = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE_S = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Unused codes 101-111 fall through to word accesses.
    function automatic size_t access_size(input logic [2:0] ctrl);
        case (ctrl)
            DM_HALF_S, DM_HALF_U: return SZ_HALF;
            DM_BYTE_S, DM_BYTE_U: return SZ_BYTE;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic sign_extend(input logic [2:0] ctrl);
        return (ctrl == DM_HALF_S) || (ctrl == DM_BYTE_S);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a 32-bit word bus.
// Ports:
//   ctrl       in   dm_ctrl access type
//   addr_lo    in   byte offset within the word
//   wdata      in   right-aligned store data
//   rdata      in   raw bus read word
//   be         out  store byte enables
//   bus_wdata  out  lane-replicated store data
//   ext_rdata  out  lane-selected, sign/zero-extended load data
//   misaligned out  access crosses its natural alignment
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] ext_rdata,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic        sgn;

    // Lane selection, replication and extension per access size.
    always_comb begin
        be         = 4'hF;
        bus_wdata  = wdata;
        ext_rdata  = rdata;
        misaligned = 1'b0;
        sgn        = sign_extend(ctrl);
        shifted    = rdata >> {addr_lo, 3'b000};
        case (access_size(ctrl))
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
                ext_rdata = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be         = 4'b0011 << addr_lo;
                bus_wdata  = {2{wdata[15:0]}};
                ext_rdata  = {{16{sgn & shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage between the CPU core and a word-addressed bus.
// Ports:
//   clk, reset                 clock, async active-low reset
//   cpu_req/we/addr/wdata      core request, held until cpu_done
//   dm_ctrl                    access type
//   cpu_rdata/done/err         registered completion (one-cycle done pulse)
//   cpu_stall                  combinational core hold
//   bus_req/we/addr/be/wdata   registered bus request
//   bus_rdata, bus_ready       bus response
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        dm_ctrl,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_n;
    logic              we_q, we_n;
    logic [2:0]        ctrl_q, ctrl_n;
    logic [1:0]        lo_q, lo_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              bus_req_n, bus_we_n, done_n, err_n;
    logic [ADDR_W-1:0] bus_addr_n;
    logic [3:0]        bus_be_n;
    logic [31:0]       bus_wdata_n, rdata_n;

    logic [2:0]        al_ctrl;
    logic [1:0]        al_lo;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_ext;
    logic              al_mis;
    logic              timed_out;

    // Aligner sees the live request in IDLE and the latched one afterwards.
    assign al_ctrl   = (state == ST_IDLE) ? dm_ctrl : ctrl_q;
    assign al_lo     = (state == ST_IDLE) ? cpu_addr[1:0] : lo_q;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign cpu_stall = cpu_req & (state != ST_RESP);

    mem_lane_align u_align (
        .ctrl       (al_ctrl),
        .addr_lo    (al_lo),
        .wdata      (cpu_wdata),
        .rdata      (bus_rdata),
        .be         (al_be),
        .bus_wdata  (al_wdata),
        .ext_rdata  (al_ext),
        .misaligned (al_mis)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            ctrl_q    <= DM_WORD;
            lo_q      <= 2'b00;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'h0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            state     <= state_n;
            we_q      <= we_n;
            ctrl_q    <= ctrl_n;
            lo_q      <= lo_n;
            cnt       <= cnt_n;
            bus_req   <= bus_req_n;
            bus_we    <= bus_we_n;
            bus_addr  <= bus_addr_n;
            bus_be    <= bus_be_n;
            bus_wdata <= bus_wdata_n;
            cpu_rdata <= rdata_n;
            cpu_done  <= done_n;
            cpu_err   <= err_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        we_n        = we_q;
        ctrl_n      = ctrl_q;
        lo_n        = lo_q;
        cnt_n       = cnt;
        bus_req_n   = bus_req;
        bus_we_n    = bus_we;
        bus_addr_n  = bus_addr;
        bus_be_n    = bus_be;
        bus_wdata_n = bus_wdata;
        rdata_n     = cpu_rdata;
        done_n      = 1'b0;
        err_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_n        = cpu_we;
                    ctrl_n      = dm_ctrl;
                    lo_n        = cpu_addr[1:0];
                    bus_addr_n  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_n = al_wdata;
                    if (al_mis) begin
                        state_n = ST_RESP;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else begin
                        state_n   = ST_BUS;
                        bus_req_n = 1'b1;
                        bus_we_n  = cpu_we;
                        bus_be_n  = cpu_we ? al_be : 4'hF;
                        cnt_n     = '0;
                    end
                end
            end
            ST_BUS: begin
                if (bus_ready || timed_out) begin
                    state_n   = ST_RESP;
                    done_n    = 1'b1;
                    err_n     = !bus_ready;
                    rdata_n   = (bus_ready && !we_q) ? al_ext : 32'h0;
                    bus_req_n = 1'b0;
                    bus_we_n  = 1'b0;
                    bus_be_n  = 4'h0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dm_ctrl   (dm_ctrl),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] ctrl);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        dm_ctrl   = ctrl;
    endtask

    // Runs one access with bus_ready held high; returns latency in cycles
    // (request cycle counts as 1), the response and whether bus_req was seen.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] ctrl, input logic [31:0] rd,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output logic saw_req);
        drive(we, addr, wd, ctrl);
        bus_rdata = rd;
        bus_ready = 1'b1;
        lat       = 1;
        saw_req   = 1'b0;
        while (!cpu_done && lat < 20) begin
            step();
            lat++;
            saw_req = saw_req | bus_req;
        end
        rdata     = cpu_rdata;
        err       = cpu_err;
        cpu_req   = 1'b0;
        bus_ready = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          nreq;
        logic [31:0] rd;
        logic        er, sr;

        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dm_ctrl   = 3'b000;
        bus_rdata = '0;
        bus_ready = 1'b0;
        #1;
        check("rst_bus_req",   32'(bus_req),  32'h0);
        check("rst_bus_we",    32'(bus_we),   32'h0);
        check("rst_cpu_done",  32'(cpu_done), 32'h0);
        check("rst_cpu_err",   32'(cpu_err),  32'h0);
        check("rst_bus_be",    32'(bus_be),   32'h0);
        check("rst_bus_addr",  bus_addr,      32'h0);
        check("rst_bus_wdata", bus_wdata,     32'h0);
        check("rst_cpu_rdata", cpu_rdata,     32'h0);
        step();
        step();
        reset = 1'b1;
        step();

        // 1: word load, ready on first BUS cycle
        drive(1'b0, 32'h100, 32'h0, 3'b000);
        bus_rdata = 32'hDEADBEEF;
        bus_ready = 1'b1;
        #1;
        check("t1_c1_stall",   32'(cpu_stall), 32'h1);
        check("t1_c1_busreq",  32'(bus_req),   32'h0);
        step();
        check("t1_c2_busreq",  32'(bus_req),   32'h1);
        check("t1_c2_addr",    bus_addr,       32'h100);
        check("t1_c2_be",      32'(bus_be),    32'hF);
        check("t1_c2_we",      32'(bus_we),    32'h0);
        check("t1_c2_stall",   32'(cpu_stall), 32'h1);
        check("t1_c2_done",    32'(cpu_done),  32'h0);
        step();
        check("t1_c3_done",    32'(cpu_done),  32'h1);
        check("t1_c3_rdata",   cpu_rdata,      32'hDEADBEEF);
        check("t1_c3_err",     32'(cpu_err),   32'h0);
        check("t1_c3_stall",   32'(cpu_stall), 32'h0);
        check("t1_c3_busreq",  32'(bus_req),   32'h0);
        cpu_req   = 1'b0;
        bus_ready = 1'b0;
        step();
        check("t1_c4_done",    32'(cpu_done),  32'h0);

        // 2: sub-word loads with extension
        access(1'b0, 32'h103, 32'h0, 3'b011, 32'h80FF0011, lat, rd, er, sr);
        check("t2_bs_lat",   32'(lat), 32'd3);
        check("t2_bs_rdata", rd,       32'hFFFFFF80);
        access(1'b0, 32'h103, 32'h0, 3'b100, 32'h80FF0011, lat, rd, er, sr);
        check("t2_bu_rdata", rd,       32'h00000080);
        access(1'b0, 32'h102, 32'h0, 3'b010, 32'h80FF0011, lat, rd, er, sr);
        check("t2_hu_rdata", rd,       32'h000080FF);
        access(1'b0, 32'h102, 32'h0, 3'b001, 32'h80FF0011, lat, rd, er, sr);
        check("t2_hs_rdata", rd,       32'hFFFF80FF);
        access(1'b0, 32'h100, 32'h0, 3'b011, 32'h80FF0011, lat, rd, er, sr);
        check("t2_b0_rdata", rd,       32'h00000011);
        access(1'b0, 32'h101, 32'h0, 3'b011, 32'h80FF0011, lat, rd, er, sr);
        check("t2_b1_rdata", rd,       32'h00000000);
        check("t2_b1_err",   32'(er),  32'h0);
        access(1'b0, 32'h100, 32'h0, 3'b111, 32'h12345678, lat, rd, er, sr);
        check("t2_code7_rdata", rd,    32'h12345678);

        // 3: byte store, inputs changed mid-BUS must be ignored
        drive(1'b1, 32'h201, 32'h000000A5, 3'b100);
        bus_ready = 1'b0;
        step();
        check("t3_b_busreq", 32'(bus_req), 32'h1);
        check("t3_b_we",     32'(bus_we),  32'h1);
        check("t3_b_be",     32'(bus_be),  32'h2);
        check("t3_b_wdata",  bus_wdata,    32'hA5A5A5A5);
        check("t3_b_addr",   bus_addr,     32'h200);
        drive(1'b0, 32'h7FC, 32'h11223344, 3'b000);
        step();
        check("t3_b_hold_wdata", bus_wdata,    32'hA5A5A5A5);
        check("t3_b_hold_be",    32'(bus_be),  32'h2);
        check("t3_b_hold_addr",  bus_addr,     32'h200);
        bus_rdata = 32'hFFFFFFFF;
        bus_ready = 1'b1;
        step();
        check("t3_b_done",  32'(cpu_done), 32'h1);
        check("t3_b_rdata", cpu_rdata,     32'h0);
        check("t3_b_err",   32'(cpu_err),  32'h0);
        cpu_req   = 1'b0;
        bus_ready = 1'b0;
        step();

        drive(1'b1, 32'h202, 32'h00001234, 3'b010);
        step();
        check("t3_h_be",    32'(bus_be), 32'hC);
        check("t3_h_wdata", bus_wdata,   32'h12341234);
        check("t3_h_addr",  bus_addr,    32'h200);
        bus_ready = 1'b1;
        step();
        check("t3_h_done",  32'(cpu_done), 32'h1);
        cpu_req   = 1'b0;
        bus_ready = 1'b0;
        step();

        // 4: misaligned accesses never reach the bus
        access(1'b0, 32'h102, 32'h0, 3'b000, 32'hCAFEF00D, lat, rd, er, sr);
        check("t4_w_lat",   32'(lat), 32'd2);
        check("t4_w_err",   32'(er),  32'h1);
        check("t4_w_rdata", rd,       32'h0);
        check("t4_w_noreq", 32'(sr),  32'h0);
        access(1'b1, 32'h101, 32'hBEEF, 3'b001, 32'h0, lat, rd, er, sr);
        check("t4_h_err",   32'(er),  32'h1);
        check("t4_h_noreq", 32'(sr),  32'h0);

        // 5: timeout after TO bus cycles; late ready is ignored
        access(1'b0, 32'h300, 32'h0, 3'b000, 32'h55AA55AA, lat, rd, er, sr);
        check("t5_pre_rdata", rd, 32'h55AA55AA);
        drive(1'b0, 32'h300, 32'h0, 3'b000);
        bus_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus_req) nreq++;
            if (cpu_done) break;
        end
        check("t5_req_cycles", 32'(nreq),     32'(TO));
        check("t5_done",       32'(cpu_done), 32'h1);
        check("t5_err",        32'(cpu_err),  32'h1);
        check("t5_rdata",      cpu_rdata,     32'h0);
        cpu_req = 1'b0;
        step();
        bus_ready = 1'b1;
        step();
        check("t5_late_done",   32'(cpu_done), 32'h0);
        check("t5_late_busreq", 32'(bus_req),  32'h0);
        step();
        check("t5_late_done2",  32'(cpu_done), 32'h0);
        bus_ready = 1'b0;

        // 6: reset mid-BUS, then normal operation
        drive(1'b0, 32'h400, 32'h0, 3'b000);
        step();
        check("t6_busreq", 32'(bus_req), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_busreq", 32'(bus_req),  32'h0);
        check("t6_rst_done",   32'(cpu_done), 32'h0);
        cpu_req = 1'b0;
        step();
        check("t6_rst_done2",  32'(cpu_done), 32'h0);
        reset = 1'b1;
        step();
        access(1'b0, 32'h404, 32'h0, 3'b000, 32'h0BADC0DE, lat, rd, er, sr);
        check("t6_post_lat",   32'(lat), 32'd3);
        check("t6_post_rdata", rd,       32'h0BADC0DE);
        check("t6_post_err",   32'(er),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the CPU core.
- Consumes the core's memory request (address, store data, write strobe, dm_ctrl access type) and drives a word-addressed system bus with a ready handshake.
- Returns load data already lane-selected and sign/zero-extended, stalls the core until the access completes, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 64: bus-wait cycles before abort; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory access valid (load or store); held until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- dm_ctrl  in  3  access type.
- cpu_rdata  out  32  extended load data; valid when cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  misalign/timeout flag; valid with cpu_done.
- cpu_stall  out  1  hold core.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  bus read word.
- bus_ready  in  1  bus completion (MIO_ready).

Behaviour:
- dm_ctrl codes: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Codes 101-111 are treated as word.
- Reset (reset=0, asynchronous): state IDLE; bus_req, bus_we, cpu_done, cpu_err all 0; bus_be=0; bus_addr, bus_wdata, cpu_rdata = 0; timeout counter = 0.
- FSM states: IDLE, BUS, RESP.
- IDLE, cpu_req=1:
  - Latch we, addr, wdata, dm_ctrl.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1; no bus cycle issued.
  - Otherwise: go to BUS.
- BUS:
  - bus_req=1 and bus_we=latched we; outputs come from registers, stable for the whole state.
  - On bus_ready=1: capture the extended read data, go to RESP with err=0.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - Counter clears on BUS entry.
- RESP:
  - cpu_done=1 for exactly one cycle; cpu_err and cpu_rdata valid (rdata=0 on stores and errors).
  - Next state is always IDLE.
- cpu_stall = cpu_req & (state != RESP), combinational.
- Minimum latency: 3 cycles (IDLE→BUS with ready on first BUS cycle→RESP).
- Back-to-back requests: one IDLE cycle between accesses, since a req present in IDLE after RESP starts a new access.
- Store lanes (k = addr[1:0]):
  - byte: be=1<<k, wdata={4{wdata[7:0]}}.
  - half: be=2'b11<<k, wdata={2{wdata[15:0]}}.
  - word: be=4'hF, wdata as-is.
- Loads: bus_be=4'hF. Select the byte at bus_rdata[8k+7:8k] or the half at bus_rdata[8k+15:8k] (k ∈ {0,2}), then sign- or zero-extend per dm_ctrl.
- Input changes while in BUS/RESP are ignored; latched values are used.
- bus_ready outside BUS is ignored.
- cpu_req dropping mid-BUS does not abort the bus cycle; it completes and cpu_done still pulses.
- Reset mid-BUS: bus_req drops asynchronously; no cpu_done.

Decomposition:
- Package mem_access_pkg: dm_ctrl code constants, FSM state encoding (2-bit), TIMEOUT default.
- Combinational sub-module mem_lane_align: (dm_ctrl, addr[1:0], wdata, rdata) → (be, bus_wdata, ext_rdata, misaligned).
- Top: FSM, latches, timeout counter.

Test Plan:
1. Word load, addr 0x100, bus_rdata=0xDEADBEEF, ready on first BUS cycle → bus_be=F, bus_addr=0x100, cpu_done in cycle 3, cpu_rdata=0xDEADBEEF, stall high for 2 cycles.
2. Signed byte load, addr 0x103, bus_rdata=0x80FF0011 → cpu_rdata=0xFFFFFF80. Unsigned byte at the same address → 0x00000080. Unsigned half at 0x102 → 0x000080FF.
3. Byte store 0x000000A5 at addr 0x201 → bus_be=4'b0010, bus_wdata=0xA5A5A5A5, bus_we=1, bus_addr=0x200. Half store at 0x202 → be=4'b1100.
4. Word load at 0x102 (misaligned) → no bus_req ever asserted, cpu_done and cpu_err in cycle 2, cpu_rdata=0.
5. TIMEOUT=4, bus_ready held 0 → bus_req high exactly 4 cycles, then cpu_done=1, cpu_err=1, cpu_rdata=0. bus_ready pulsed afterwards → no effect.
6. reset pulled low during BUS with ready delayed → bus_req drops the same cycle, no cpu_done. After release, a new word load completes normally.
